bram_rr_arbiter: RTL and testbench

//  Shares one single-port block RAM (blk_mem_gen, native port A) between two requesters.

---
 rtl/bram_rr_arbiter_if.sv | 50 +++++
 rtl/bram_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_bram_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_rr_arbiter_if.sv
// Request/response and RAM-side signal bundle for bram_rr_arbiter.
// slave = the arbiter; master = the surrounding clients plus the RAM.
interface bram_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  bram_ena;
  logic                  bram_wea;
  logic [ADDR_WIDTH-1:0] bram_addra;
  logic [DATA_WIDTH-1:0] bram_dina;
  logic [DATA_WIDTH-1:0] bram_douta;

  logic                  init_done;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  bram_douta,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output bram_ena, bram_wea, bram_addra, bram_dina,
    output init_done
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output bram_douta,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  bram_ena, bram_wea, bram_addra, bram_dina,
    input  init_done
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Two-client round-robin front end for a single-port block RAM.
// Zero-fills the RAM after reset, then grants one access per cycle and
// steers read data back to its owner after the RAM read latency.
module bram_rr_arbiter #(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  ADDR_WIDTH   = 4,
  parameter int                  READ_LATENCY = 1,
  parameter int                  INIT_EN      = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clka,
  input  logic               rsta,
  bram_rr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2} state_t;

  localparam logic [ADDR_WIDTH-1:0] FILL_LAST = '1;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   fill_cnt;
  logic                    prio;
  logic                    gnt0, gnt1;
  logic                    rd_now, own_now;
  // stage i holds the read issued i cycles ago; the top stage meets douta
  logic [READ_LATENCY:1]   vld_pipe, own_pipe;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;

  // state register; reset always lands in IDLE
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state, arbitration and RAM port drive
  always_comb begin
    state_nxt      = state;
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    bus.bram_ena   = 1'b0;
    bus.bram_wea   = 1'b0;
    bus.bram_addra = '0;
    bus.bram_dina  = '0;
    case (state)
      IDLE: state_nxt = (INIT_EN != 0) ? INIT : RUN;
      INIT: begin
        bus.bram_ena   = 1'b1;
        bus.bram_wea   = 1'b1;
        bus.bram_addra = fill_cnt;
        bus.bram_dina  = INIT_VALUE;
        if (fill_cnt == FILL_LAST) state_nxt = RUN;
      end
      RUN: begin
        // a lone requester always wins; a tie goes to whoever prio names
        gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio);
        gnt1 = bus.req1_valid & (~bus.req0_valid |  prio);
        if (gnt0) begin
          bus.bram_ena   = 1'b1;
          bus.bram_wea   = bus.req0_we;
          bus.bram_addra = bus.req0_addr;
          bus.bram_dina  = bus.req0_wdata;
        end else if (gnt1) begin
          bus.bram_ena   = 1'b1;
          bus.bram_wea   = bus.req1_we;
          bus.bram_addra = bus.req1_addr;
          bus.bram_dina  = bus.req1_wdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.init_done  = (state == RUN);

  assign rd_now  = (gnt0 & ~bus.req0_we) | (gnt1 & ~bus.req1_we);
  assign own_now = gnt1;

  // fill address walks 0..depth-1 while in INIT, parked at 0 otherwise
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)                fill_cnt <= '0;
    else if (state == INIT)  fill_cnt <= fill_cnt + 1'b1;
    else                     fill_cnt <= '0;
  end

  // the tie priority flips to the loser of each grant
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta)      prio <= 1'b0;
    else if (gnt0) prio <= 1'b1;
    else if (gnt1) prio <= 1'b0;
  end

  // read-tracking shift pipe; reset drops any reads in flight
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_now;
      own_pipe[1] <= own_now;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign bus.rsp0_valid = vld_pipe[READ_LATENCY] & ~own_pipe[READ_LATENCY];
  assign bus.rsp1_valid = vld_pipe[READ_LATENCY] &  own_pipe[READ_LATENCY];

  // keep the last delivered word per requester so rdata holds between pulses
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (bus.rsp0_valid) rdata0_q <= bus.bram_douta;
      if (bus.rsp1_valid) rdata1_q <= bus.bram_douta;
    end
  end

  assign bus.rsp0_rdata = bus.rsp0_valid ? bus.bram_douta : rdata0_q;
  assign bus.rsp1_rdata = bus.rsp1_valid ? bus.bram_douta : rdata1_q;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: two instances (read latency 1 and 2) share one
// stimulus stream, each backed by a behavioural RAM and a response scoreboard.
module tb_bram_rr_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  bram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
                    .INIT_EN(1), .INIT_VALUE(8'h00))
    dut_a (.clka(clk), .rsta(rst), .bus(ifa.slave));
  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
                    .INIT_EN(1), .INIT_VALUE(8'h00))
    dut_b (.clka(clk), .rsta(rst), .bus(ifb.slave));

  // instance b mirrors instance a's requests
  assign ifb.req0_valid = ifa.req0_valid;
  assign ifb.req0_we    = ifa.req0_we;
  assign ifb.req0_addr  = ifa.req0_addr;
  assign ifb.req0_wdata = ifa.req0_wdata;
  assign ifb.req1_valid = ifa.req1_valid;
  assign ifb.req1_we    = ifa.req1_we;
  assign ifb.req1_addr  = ifa.req1_addr;
  assign ifb.req1_wdata = ifa.req1_wdata;

  // behavioural write-first RAMs
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] dout_a, dout_b1, dout_b2;
  always @(posedge clk) begin
    if (ifa.bram_ena) begin
      if (ifa.bram_wea) begin
        mem_a[ifa.bram_addra] <= ifa.bram_dina;
        dout_a <= ifa.bram_dina;
      end else dout_a <= mem_a[ifa.bram_addra];
    end
    if (ifb.bram_ena) begin
      if (ifb.bram_wea) begin
        mem_b[ifb.bram_addra] <= ifb.bram_dina;
        dout_b1 <= ifb.bram_dina;
      end else dout_b1 <= mem_b[ifb.bram_addra];
    end
    dout_b2 <= dout_b1;
  end
  assign ifa.bram_douta = dout_a;
  assign ifb.bram_douta = dout_b2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic owner; logic [DW-1:0] data; int due; } exp_t;
  exp_t qa [$];
  exp_t qb [$];
  logic [DW-1:0] shadow [DEPTH];
  int glog [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard step for one instance: push expected reads at grant, pop at pulse
  task automatic mon(input int inst, input int rl, input logic hs0, hs1, we0, we1,
                     input logic [AW-1:0] a0, a1, input logic rv0, rv1,
                     input logic [DW-1:0] rd0, rd1);
    exp_t e;
    int   sz;
    if (hs0 || hs1) chk($sformatf("single_grant%0d", inst), hs0 & hs1, 0);
    if (hs0 && !we0) begin
      e.owner = 1'b0; e.data = shadow[a0]; e.due = cyc + rl;
      if (inst == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (hs1 && !we1) begin
      e.owner = 1'b1; e.data = shadow[a1]; e.due = cyc + rl;
      if (inst == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (rv0 || rv1) begin
      chk($sformatf("rsp_both%0d", inst), rv0 & rv1, 0);
      sz = (inst == 0) ? qa.size() : qb.size();
      chk($sformatf("rsp_expected%0d", inst), sz > 0, 1);
      if (sz > 0) begin
        e = (inst == 0) ? qa.pop_front() : qb.pop_front();
        chk($sformatf("rsp_owner%0d", inst), rv1, e.owner);
        chk($sformatf("rsp_data%0d", inst), rv1 ? rd1 : rd0, e.data);
        chk($sformatf("rsp_cycle%0d", inst), cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      foreach (shadow[i]) shadow[i] = 8'h00;
    end else begin
      mon(0, 1, ifa.req0_valid & ifa.req0_ready, ifa.req1_valid & ifa.req1_ready,
          ifa.req0_we, ifa.req1_we, ifa.req0_addr, ifa.req1_addr,
          ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_rdata, ifa.rsp1_rdata);
      mon(1, 2, ifb.req0_valid & ifb.req0_ready, ifb.req1_valid & ifb.req1_ready,
          ifb.req0_we, ifb.req1_we, ifb.req0_addr, ifb.req1_addr,
          ifb.rsp0_valid, ifb.rsp1_valid, ifb.rsp0_rdata, ifb.rsp1_rdata);
      if (ifa.req0_valid && ifa.req0_ready) begin
        glog.push_back(0);
        if (ifa.req0_we) shadow[ifa.req0_addr] = ifa.req0_wdata;
      end
      if (ifa.req1_valid && ifa.req1_ready) begin
        glog.push_back(1);
        if (ifa.req1_we) shadow[ifa.req1_addr] = ifa.req1_wdata;
      end
    end
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a"}, {ifa.req0_ready, ifa.req1_ready, ifa.rsp0_valid, ifa.rsp1_valid,
                      ifa.rsp0_rdata, ifa.rsp1_rdata, ifa.bram_ena, ifa.bram_wea,
                      ifa.bram_addra, ifa.bram_dina, ifa.init_done}, 0);
    chk({tag, "_b"}, {ifb.req0_ready, ifb.req1_ready, ifb.rsp0_valid, ifb.rsp1_valid,
                      ifb.rsp0_rdata, ifb.rsp1_rdata, ifb.bram_ena, ifb.bram_wea,
                      ifb.bram_addra, ifb.bram_dina, ifb.init_done}, 0);
  endtask

  // walk the fill: one write per cycle at addr k-1, ready low, init_done at k=17
  task automatic chk_fill(input string tag);
    logic [AW-1:0] ea;
    int k    = 0;
    int nwr  = 0;
    bit done = 0;
    while (!done && k < 40) begin
      k++;
      @(posedge clk);
      @(negedge clk);
      if (ifa.init_done) begin
        done = 1;
        chk({tag, "_done_cycle"}, k, 17);
        chk({tag, "_done_b"}, ifb.init_done, 1);
      end else begin
        nwr++;
        ea = 4'(k - 1);
        chk($sformatf("%s_k%0d_a", tag, k),
            {ifa.bram_ena, ifa.bram_wea, ifa.bram_addra, ifa.bram_dina, ifa.req0_ready, ifa.req1_ready},
            {1'b1, 1'b1, ea, 8'h00, 1'b0, 1'b0});
        chk($sformatf("%s_k%0d_b", tag, k), {ifb.bram_ena, ifb.bram_addra}, {1'b1, ea});
      end
    end
    chk({tag, "_finished"}, done, 1);
    chk({tag, "_writes"}, nwr, 16);
  endtask

  logic [31:0] got;

  initial begin
    ifa.req0_valid = 0; ifa.req0_we = 0; ifa.req0_addr = '0; ifa.req0_wdata = '0;
    ifa.req1_valid = 0; ifa.req1_we = 0; ifa.req1_addr = '0; ifa.req1_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst0");

    // a read held pending across the fill must not be granted until RUN
    ifa.req0_valid = 1; ifa.req0_we = 0; ifa.req0_addr = 4'd0;
    @(posedge clk); #1 rst = 0;
    chk_fill("fill0");
    chk("init_first_grant", ifa.req0_ready, 1);

    // write 0xA5 @3 then read it straight back
    @(posedge clk); #1;
    ifa.req0_we = 1; ifa.req0_addr = 4'd3; ifa.req0_wdata = 8'hA5;
    @(negedge clk); chk("wr_a5_grant", ifa.req0_ready, 1);
    @(posedge clk); #1 ifa.req0_we = 0;
    @(negedge clk); chk("rd_a5_grant", ifa.req0_ready, 1);
    @(posedge clk); #1 ifa.req0_valid = 0;
    @(negedge clk);
    chk("rd_a5_rsp", {ifa.rsp0_valid, ifa.rsp1_valid, ifa.rsp0_rdata}, {1'b1, 1'b0, 8'hA5});
    @(posedge clk);
    @(negedge clk);
    chk("rd_a5_hold", {ifa.rsp0_valid, ifa.rsp0_rdata}, {1'b0, 8'hA5});

    // distinct data at 1 and 2; req1 writes last so the next tie goes to 0
    @(posedge clk); #1;
    ifa.req0_valid = 1; ifa.req0_we = 1; ifa.req0_addr = 4'd1; ifa.req0_wdata = 8'h11;
    @(negedge clk); chk("wr_11_grant", ifa.req0_ready, 1);
    @(posedge clk); #1;
    ifa.req0_valid = 0;
    ifa.req1_valid = 1; ifa.req1_we = 1; ifa.req1_addr = 4'd2; ifa.req1_wdata = 8'h22;
    @(negedge clk); chk("wr_22_grant", ifa.req1_ready, 1);

    // both reading every cycle: grants alternate 0,1,0,1,...
    @(posedge clk); #1;
    ifa.req0_valid = 1; ifa.req0_we = 0; ifa.req0_addr = 4'd1;
    ifa.req1_valid = 1; ifa.req1_we = 0; ifa.req1_addr = 4'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("alt_%0d", i), {ifa.req0_ready, ifa.req1_ready},
          (i % 2 == 0) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
    end

    // req1 alone gets every cycle; a following tie goes to 0
    ifa.req0_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("solo1_%0d", i), {ifa.req0_ready, ifa.req1_ready}, 2'b01);
      @(posedge clk); #1;
    end
    ifa.req0_valid = 1;
    @(negedge clk);
    chk("tie_after_solo", {ifa.req0_ready, ifa.req1_ready}, 2'b10);
    @(posedge clk); #1;
    ifa.req0_valid = 0; ifa.req1_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // reset right after a read grant: the response is dropped, fill re-runs
    ifa.req0_valid = 1; ifa.req0_we = 0; ifa.req0_addr = 4'd3;
    @(negedge clk); chk("rst_rd_grant", ifa.req0_ready, 1);
    @(posedge clk); #1;
    ifa.req0_valid = 0; rst = 1;
    @(negedge clk); chk_reset_outs("rst_mid0");
    @(posedge clk);
    @(negedge clk); chk_reset_outs("rst_mid1");
    @(posedge clk); #1 rst = 0;
    chk_fill("fill1");

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("grant_count", glog.size(), 18);
    got = '0;
    foreach (glog[i]) got = {got[30:0], glog[i][0]};
    chk("grant_order", got, 32'b000010101011111100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end
endmodule
